// File: rtl/rx_payload_extract_pkg.sv
// Shared widths, FSM encoding, header payload struct and dst-MAC filter for rx_payload_extract.
package rx_payload_extract_pkg;

  localparam int unsigned GMII_DATA_W  = 8;
  localparam int unsigned MAC_ADDR_W   = 48;
  localparam int unsigned ETHER_TYPE_W = 16;
  localparam int unsigned FCS_BYTES    = 4;
  localparam int unsigned STRIP_DEPTH  = FCS_BYTES + 1;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_HDR     = 2'd1,
    RX_PAYLOAD = 2'd2,
    RX_DISCARD = 2'd3
  } rx_extract_state_e;

  typedef struct packed {
    logic [MAC_ADDR_W-1:0]   dst;
    logic [MAC_ADDR_W-1:0]   src;
    logic [ETHER_TYPE_W-1:0] ether_type;
  } rx_hdr_t;

  // Accept own unicast, optionally broadcast, optionally any group address (I/G bit).
  function automatic logic mac_accept(input logic [MAC_ADDR_W-1:0] dst,
                                      input logic [MAC_ADDR_W-1:0] local_mac,
                                      input logic                  bcast_en,
                                      input logic                  mcast_en);
    return (dst == local_mac) |
           (bcast_en & (dst == {MAC_ADDR_W{1'b1}})) |
           (mcast_en & dst[40]);
  endfunction

endpackage

// File: rtl/rx_payload_extract_if.sv
// Byte-stream input and framed payload/header output bundle of rx_payload_extract.
interface rx_payload_extract_if;
  import rx_payload_extract_pkg::*;

  logic [GMII_DATA_W-1:0]  rx_data_i;
  logic                    rx_data_valid_i;
  logic                    is_preamble_or_sfd_i;
  logic                    is_dst_mac_i;
  logic                    is_src_mac_i;
  logic                    is_ether_type_i;
  logic                    is_payload_or_crc_i;
  logic                    invalid_frame_i;

  logic                    hdr_valid_o;
  logic [MAC_ADDR_W-1:0]   dst_mac_o;
  logic [MAC_ADDR_W-1:0]   src_mac_o;
  logic [ETHER_TYPE_W-1:0] ether_type_o;
  logic [GMII_DATA_W-1:0]  pl_data_o;
  logic                    pl_valid_o;
  logic                    pl_first_o;
  logic                    pl_last_o;
  logic                    pl_err_o;
  logic                    frame_drop_o;

  modport slave (
    input  rx_data_i, rx_data_valid_i, is_preamble_or_sfd_i, is_dst_mac_i,
           is_src_mac_i, is_ether_type_i, is_payload_or_crc_i, invalid_frame_i,
    output hdr_valid_o, dst_mac_o, src_mac_o, ether_type_o, pl_data_o,
           pl_valid_o, pl_first_o, pl_last_o, pl_err_o, frame_drop_o
  );

  modport master (
    output rx_data_i, rx_data_valid_i, is_preamble_or_sfd_i, is_dst_mac_i,
           is_src_mac_i, is_ether_type_i, is_payload_or_crc_i, invalid_frame_i,
    input  hdr_valid_o, dst_mac_o, src_mac_o, ether_type_o, pl_data_o,
           pl_valid_o, pl_first_o, pl_last_o, pl_err_o, frame_drop_o
  );

endinterface

// File: rtl/rx_fcs_strip_delay.sv
// Byte delay line with fill count; the oldest entry is valid to read once the line is full.
module rx_fcs_strip_delay #(
  parameter int unsigned DEPTH = 5,
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_flush,
  input  logic [W-1:0]     i_data,
  output logic [W-1:0]     o_oldest,
  output logic [CNT_W-1:0] o_depth
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [CNT_W-1:0] r_depth;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_depth <= '0;
    end else if (i_flush) begin
      r_depth <= '0;
    end else if (i_push) begin
      r_mem[0] <= i_data;
      for (int unsigned i = 1; i < DEPTH; i++) r_mem[i] <= r_mem[i-1];
      if (r_depth != CNT_W'(DEPTH)) r_depth <= r_depth + CNT_W'(1);
    end
  end

  assign o_oldest = r_mem[DEPTH-1];
  assign o_depth  = r_depth;

endmodule

// File: rtl/rx_payload_extract.sv
// Header capture, dst-MAC filter and FCS strip downstream of rx_mac_top.
// Optional RX_STATS_EN adds saturating good/bad/drop frame counters.
module rx_payload_extract
  import rx_payload_extract_pkg::*;
#(
  parameter logic [MAC_ADDR_W-1:0] LOCAL_MAC    = 48'h02_00_00_00_00_01,
  parameter bit                    ACCEPT_BCAST = 1'b1,
  parameter bit                    ACCEPT_MCAST = 1'b0,
  parameter int unsigned           STAT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  rx_payload_extract_if.slave  bus,
  output logic [STAT_W-1:0]    stat_good_o,
  output logic [STAT_W-1:0]    stat_bad_o,
  output logic [STAT_W-1:0]    stat_drop_o
);

  localparam logic [1:0]  ST_IDLE    = RX_IDLE;
  localparam logic [1:0]  ST_HDR     = RX_HDR;
  localparam logic [1:0]  ST_PAYLOAD = RX_PAYLOAD;
  localparam logic [1:0]  ST_DISCARD = RX_DISCARD;
  localparam int unsigned DCNT_W     = $clog2(STRIP_DEPTH + 1);
  localparam int unsigned SHIFT_W    = MAC_ADDR_W - GMII_DATA_W;

  logic [1:0]             r_state, w_state_nxt;
  rx_hdr_t                r_hdr_sh, w_hdr_sh_nxt;
  rx_hdr_t                r_hdr, w_hdr_nxt;
  logic                   r_err, w_err_nxt;
  logic                   r_emitted, w_emitted_nxt;
  logic [GMII_DATA_W-1:0] r_pl_data, w_pl_data_nxt;
  logic                   r_pl_valid, w_pl_valid_nxt;
  logic                   r_pl_first, w_pl_first_nxt;
  logic                   r_pl_last, w_pl_last_nxt;
  logic                   r_pl_err, w_pl_err_nxt;
  logic                   r_hdr_valid, w_hdr_valid_nxt;
  logic                   r_drop, w_drop_nxt;

  logic                   w_push, w_flush, w_full, w_byte_ok, w_err_acc;
  logic [GMII_DATA_W-1:0] w_oldest;
  logic [DCNT_W-1:0]      w_depth;

  rx_fcs_strip_delay #(
    .DEPTH (STRIP_DEPTH),
    .W     (GMII_DATA_W),
    .CNT_W (DCNT_W)
  ) u_strip (
    .clk      (clk),
    .rst      (rst),
    .i_push   (w_push),
    .i_flush  (w_flush),
    .i_data   (bus.rx_data_i),
    .o_oldest (w_oldest),
    .o_depth  (w_depth)
  );

  assign w_full    = (w_depth == DCNT_W'(STRIP_DEPTH));
  assign w_byte_ok = bus.rx_data_valid_i & ~bus.is_preamble_or_sfd_i;
  assign w_err_acc = r_err | bus.invalid_frame_i;

  always_comb begin
    w_state_nxt     = r_state;
    w_hdr_sh_nxt    = r_hdr_sh;
    w_hdr_nxt       = r_hdr;
    w_err_nxt       = w_err_acc;
    w_emitted_nxt   = r_emitted;
    w_pl_data_nxt   = r_pl_data;
    w_pl_valid_nxt  = 1'b0;
    w_pl_first_nxt  = 1'b0;
    w_pl_last_nxt   = 1'b0;
    w_pl_err_nxt    = 1'b0;
    w_hdr_valid_nxt = 1'b0;
    w_drop_nxt      = 1'b0;
    w_push          = 1'b0;
    w_flush         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!bus.rx_data_valid_i) begin
          w_err_nxt = 1'b0;
        end else if (w_byte_ok && bus.is_dst_mac_i) begin
          w_state_nxt      = ST_HDR;
          w_hdr_sh_nxt.dst = {r_hdr_sh.dst[SHIFT_W-1:0], bus.rx_data_i};
        end
      end
      ST_HDR: begin
        if (!bus.rx_data_valid_i) begin
          w_state_nxt = ST_IDLE;
          w_drop_nxt  = 1'b1;
          w_err_nxt   = 1'b0;
        end else if (w_byte_ok) begin
          if (bus.is_payload_or_crc_i) begin
            if (mac_accept(r_hdr_sh.dst, LOCAL_MAC, ACCEPT_BCAST, ACCEPT_MCAST)) begin
              w_state_nxt = ST_PAYLOAD;
              w_push      = 1'b1;
            end else begin
              w_state_nxt = ST_DISCARD;
              w_drop_nxt  = 1'b1;
            end
          end else if (bus.is_dst_mac_i) begin
            w_hdr_sh_nxt.dst = {r_hdr_sh.dst[SHIFT_W-1:0], bus.rx_data_i};
          end else if (bus.is_src_mac_i) begin
            w_hdr_sh_nxt.src = {r_hdr_sh.src[SHIFT_W-1:0], bus.rx_data_i};
          end else if (bus.is_ether_type_i) begin
            w_hdr_sh_nxt.ether_type = {r_hdr_sh.ether_type[GMII_DATA_W-1:0], bus.rx_data_i};
          end
        end
      end
      ST_PAYLOAD: begin
        // End cycle: oldest byte is the last payload byte, the rest of the line is FCS.
        if (!bus.rx_data_valid_i) begin
          if (w_full) begin
            w_pl_valid_nxt  = 1'b1;
            w_pl_last_nxt   = 1'b1;
            w_pl_data_nxt   = w_oldest;
            w_pl_first_nxt  = ~r_emitted;
            w_hdr_valid_nxt = ~r_emitted;
            w_pl_err_nxt    = w_err_acc;
            if (!r_emitted) w_hdr_nxt = r_hdr_sh;
          end else begin
            w_drop_nxt = 1'b1;
          end
          w_flush       = 1'b1;
          w_emitted_nxt = 1'b0;
          w_err_nxt     = 1'b0;
          w_state_nxt   = ST_IDLE;
        end else if (w_byte_ok && bus.is_payload_or_crc_i) begin
          w_push = 1'b1;
          if (w_full) begin
            w_pl_valid_nxt  = 1'b1;
            w_pl_data_nxt   = w_oldest;
            w_pl_first_nxt  = ~r_emitted;
            w_hdr_valid_nxt = ~r_emitted;
            w_emitted_nxt   = 1'b1;
            if (!r_emitted) w_hdr_nxt = r_hdr_sh;
          end
        end
      end
      ST_DISCARD: begin
        if (!bus.rx_data_valid_i) begin
          w_state_nxt = ST_IDLE;
          w_err_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_err_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_hdr_sh    <= '0;
      r_hdr       <= '0;
      r_err       <= 1'b0;
      r_emitted   <= 1'b0;
      r_pl_data   <= '0;
      r_pl_valid  <= 1'b0;
      r_pl_first  <= 1'b0;
      r_pl_last   <= 1'b0;
      r_pl_err    <= 1'b0;
      r_hdr_valid <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hdr_sh    <= w_hdr_sh_nxt;
      r_hdr       <= w_hdr_nxt;
      r_err       <= w_err_nxt;
      r_emitted   <= w_emitted_nxt;
      r_pl_data   <= w_pl_data_nxt;
      r_pl_valid  <= w_pl_valid_nxt;
      r_pl_first  <= w_pl_first_nxt;
      r_pl_last   <= w_pl_last_nxt;
      r_pl_err    <= w_pl_err_nxt;
      r_hdr_valid <= w_hdr_valid_nxt;
      r_drop      <= w_drop_nxt;
    end
  end

  assign bus.hdr_valid_o  = r_hdr_valid;
  assign bus.dst_mac_o    = r_hdr.dst;
  assign bus.src_mac_o    = r_hdr.src;
  assign bus.ether_type_o = r_hdr.ether_type;
  assign bus.pl_data_o    = r_pl_data;
  assign bus.pl_valid_o   = r_pl_valid;
  assign bus.pl_first_o   = r_pl_first;
  assign bus.pl_last_o    = r_pl_last;
  assign bus.pl_err_o     = r_pl_err;
  assign bus.frame_drop_o = r_drop;

`ifdef RX_STATS_EN
  logic [STAT_W-1:0] r_stat_good, r_stat_bad, r_stat_drop;

  // Counters follow the registered frame outputs and stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_good <= '0;
      r_stat_bad  <= '0;
      r_stat_drop <= '0;
    end else begin
      if (r_pl_valid && r_pl_last && !r_pl_err && (r_stat_good != '1))
        r_stat_good <= r_stat_good + STAT_W'(1);
      if (r_pl_valid && r_pl_last && r_pl_err && (r_stat_bad != '1))
        r_stat_bad <= r_stat_bad + STAT_W'(1);
      if (r_drop && (r_stat_drop != '1))
        r_stat_drop <= r_stat_drop + STAT_W'(1);
    end
  end

  assign stat_good_o = r_stat_good;
  assign stat_bad_o  = r_stat_bad;
  assign stat_drop_o = r_stat_drop;
`else
  assign stat_good_o = '0;
  assign stat_bad_o  = '0;
  assign stat_drop_o = '0;
`endif

endmodule

// File: tb/tb_rx_payload_extract.sv
// Directed self-checking bench for rx_payload_extract: filtering, FCS strip, errors, runts, reset.
module tb_rx_payload_extract;
  import rx_payload_extract_pkg::*;

  localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_01;
  localparam logic [47:0] MISS  = 48'h02_00_00_00_00_02;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] MCAST = 48'h01_00_5E_00_00_01;
  localparam logic [47:0] SRC1  = 48'h00_11_22_33_44_55;
  localparam logic [47:0] SRC2  = 48'h0A_0B_0C_0D_0E_0F;
  localparam logic [4:0]  F_NONE = 5'b00000;
  localparam logic [4:0]  F_PRE  = 5'b10000;
  localparam logic [4:0]  F_DST  = 5'b01000;
  localparam logic [4:0]  F_SRC  = 5'b00100;
  localparam logic [4:0]  F_ET   = 5'b00010;
  localparam logic [4:0]  F_PL   = 5'b00001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] stat_good, stat_bad, stat_drop;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          end_cyc = 0;
  int          last_cyc = -1;
  int          drop_cnt = 0;
  int          hdr_orphan = 0;

  logic [7:0]  q_data[$];
  logic        q_first[$];
  logic        q_last[$];
  logic        q_err[$];
  rx_hdr_t     q_hdr[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rx_payload_extract_if bus();

  rx_payload_extract dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .stat_good_o (stat_good),
    .stat_bad_o  (stat_bad),
    .stat_drop_o (stat_drop)
  );

  // Capture everything the DUT emits, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.pl_valid_o) begin
        q_data.push_back(bus.pl_data_o);
        q_first.push_back(bus.pl_first_o);
        q_last.push_back(bus.pl_last_o);
        q_err.push_back(bus.pl_err_o);
        if (bus.pl_last_o) last_cyc = cyc;
      end
      if (bus.hdr_valid_o) begin
        q_hdr.push_back({bus.dst_mac_o, bus.src_mac_o, bus.ether_type_o});
        if (!(bus.pl_valid_o && bus.pl_first_o)) hdr_orphan++;
      end
      if (bus.frame_drop_o) drop_cnt++;
    end
  end

  task automatic clr_mon();
    q_data.delete(); q_first.delete(); q_last.delete(); q_err.delete(); q_hdr.delete();
    drop_cnt = 0; hdr_orphan = 0; last_cyc = -1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [4:0] f, input logic inv);
    @(posedge clk); #1;
    bus.rx_data_valid_i = v;
    bus.rx_data_i       = d;
    {bus.is_preamble_or_sfd_i, bus.is_dst_mac_i, bus.is_src_mac_i,
     bus.is_ether_type_i, bus.is_payload_or_crc_i} = f;
    bus.invalid_frame_i = inv;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, F_NONE, 1'b0);
  endtask

  task automatic send_hdr(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et);
    for (int i = 0; i < 8; i++) drive(1'b1, (i == 7) ? 8'hD5 : 8'h55, F_PRE, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, dst[47-8*i -: 8], F_DST, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, src[47-8*i -: 8], F_SRC, 1'b0);
    for (int i = 0; i < 2; i++) drive(1'b1, et[15-8*i -: 8], F_ET, 1'b0);
  endtask

  task automatic send_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                            input int npl, input logic [7:0] base, input logic inv_end);
    send_hdr(dst, src, et);
    for (int i = 0; i < npl; i++) drive(1'b1, base + 8'(i), F_PL, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hF0 + 8'(i), F_PL, 1'b0);
    drive(1'b0, 8'h00, F_NONE, inv_end);
    end_cyc = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rx_data_valid_i = 1'b0; bus.rx_data_i = 8'h00; bus.invalid_frame_i = 1'b0;
    {bus.is_preamble_or_sfd_i, bus.is_dst_mac_i, bus.is_src_mac_i,
     bus.is_ether_type_i, bus.is_payload_or_crc_i} = F_NONE;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.pl_valid_o, bus.pl_first_o, bus.pl_last_o, bus.pl_err_o, bus.hdr_valid_o, bus.frame_drop_o} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 000000",
        {bus.pl_valid_o, bus.pl_first_o, bus.pl_last_o, bus.pl_err_o, bus.hdr_valid_o, bus.frame_drop_o});
    end
    checks++;
    if ({bus.dst_mac_o, bus.src_mac_o, bus.ether_type_o, bus.pl_data_o} !== 120'h0) begin
      errors++; $display("FAIL reset_fields: got %h expected 0",
        {bus.dst_mac_o, bus.src_mac_o, bus.ether_type_o, bus.pl_data_o});
    end
    checks++;
    if ({stat_good, stat_bad, stat_drop} !== 96'h0) begin
      errors++; $display("FAIL reset_stats: got %h expected 0", {stat_good, stat_bad, stat_drop});
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_unicast(input logic inv_end);
    rx_hdr_t exp_h;
    exp_h = {LOCAL, SRC1, 16'h0800};
    clr_mon();
    send_frame(LOCAL, SRC1, 16'h0800, 46, 8'h00, inv_end);
    idle(3);
    checks++;
    if (q_data.size() !== 46) begin
      errors++; $display("FAIL uc_count(inv=%0b): got %0d expected 46", inv_end, q_data.size());
    end
    for (int i = 0; i < q_data.size(); i++) begin
      checks++;
      if ({q_data[i], q_first[i], q_last[i], q_err[i]} !== {8'(i), (i == 0), (i == 45), inv_end & (i == 45)}) begin
        errors++; $display("FAIL uc_byte%0d(inv=%0b): got d=%h f=%b l=%b e=%b expected d=%h f=%b l=%b e=%b",
          i, inv_end, q_data[i], q_first[i], q_last[i], q_err[i], 8'(i), (i == 0), (i == 45), inv_end & (i == 45));
      end
    end
    checks++;
    if (q_hdr.size() !== 1 || hdr_orphan !== 0) begin
      errors++; $display("FAIL uc_hdr_pulses: got %0d orphan %0d expected 1 orphan 0", q_hdr.size(), hdr_orphan);
    end else begin
      checks++;
      if (q_hdr[0] !== exp_h) begin
        errors++; $display("FAIL uc_hdr_fields: got %h expected %h", q_hdr[0], exp_h);
      end
    end
    checks++;
    if (last_cyc !== end_cyc + 1) begin
      errors++; $display("FAIL uc_last_latency: got cycle %0d expected %0d", last_cyc, end_cyc + 1);
    end
    checks++;
    if (drop_cnt !== 0) begin
      errors++; $display("FAIL uc_drop: got %0d expected 0", drop_cnt);
    end
  endtask

  task automatic test_filter();
    clr_mon();
    send_frame(MISS, SRC1, 16'h0800, 10, 8'h20, 1'b0);
    idle(3);
    checks++;
    if (q_data.size() !== 0 || drop_cnt !== 1) begin
      errors++; $display("FAIL filter_miss: got bytes %0d drops %0d expected 0 1", q_data.size(), drop_cnt);
    end
    clr_mon();
    send_frame(BCAST, SRC2, 16'h0806, 10, 8'h40, 1'b0);
    idle(3);
    checks++;
    if (q_data.size() !== 10 || drop_cnt !== 0) begin
      errors++; $display("FAIL filter_bcast: got bytes %0d drops %0d expected 10 0", q_data.size(), drop_cnt);
    end
    for (int i = 0; i < q_data.size(); i++) begin
      checks++;
      if ({q_data[i], q_first[i], q_last[i]} !== {8'h40 + 8'(i), (i == 0), (i == 9)}) begin
        errors++; $display("FAIL bcast_byte%0d: got d=%h f=%b l=%b expected d=%h f=%b l=%b",
          i, q_data[i], q_first[i], q_last[i], 8'h40 + 8'(i), (i == 0), (i == 9));
      end
    end
    clr_mon();
    send_frame(MCAST, SRC1, 16'h0800, 10, 8'h60, 1'b0);
    idle(3);
    checks++;
    if (q_data.size() !== 0 || drop_cnt !== 1) begin
      errors++; $display("FAIL filter_mcast: got bytes %0d drops %0d expected 0 1", q_data.size(), drop_cnt);
    end
    checks++;
    if ({bus.dst_mac_o, bus.src_mac_o, bus.ether_type_o} !== {BCAST, SRC2, 16'h0806}) begin
      errors++; $display("FAIL filter_hdr_hold: got %h expected %h",
        {bus.dst_mac_o, bus.src_mac_o, bus.ether_type_o}, {BCAST, SRC2, 16'h0806});
    end
  endtask

  task automatic test_truncated();
    clr_mon();
    for (int i = 0; i < 8; i++) drive(1'b1, (i == 7) ? 8'hD5 : 8'h55, F_PRE, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, LOCAL[47-8*i -: 8], F_DST, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, SRC1[47-8*i -: 8], F_SRC, 1'b0);
    idle(4);
    checks++;
    if (drop_cnt !== 1 || q_data.size() !== 0 || q_hdr.size() !== 0) begin
      errors++; $display("FAIL truncated: got drops %0d bytes %0d hdrs %0d expected 1 0 0",
        drop_cnt, q_data.size(), q_hdr.size());
    end
  endtask

  task automatic test_single_and_runt();
    clr_mon();
    send_frame(LOCAL, SRC2, 16'h1234, 1, 8'hA5, 1'b0);
    idle(3);
    checks++;
    if (q_data.size() !== 1 || q_hdr.size() !== 1) begin
      errors++; $display("FAIL single_count: got bytes %0d hdrs %0d expected 1 1", q_data.size(), q_hdr.size());
    end else begin
      checks++;
      if ({q_data[0], q_first[0], q_last[0], q_err[0]} !== {8'hA5, 1'b1, 1'b1, 1'b0}) begin
        errors++; $display("FAIL single_byte: got d=%h f=%b l=%b e=%b expected d=a5 f=1 l=1 e=0",
          q_data[0], q_first[0], q_last[0], q_err[0]);
      end
    end
    checks++;
    if (last_cyc !== end_cyc + 1) begin
      errors++; $display("FAIL single_latency: got cycle %0d expected %0d", last_cyc, end_cyc + 1);
    end
    clr_mon();
    send_frame(LOCAL, SRC2, 16'h1234, 0, 8'h00, 1'b0);
    idle(3);
    checks++;
    if (q_data.size() !== 0 || drop_cnt !== 1 || q_hdr.size() !== 0) begin
      errors++; $display("FAIL runt: got bytes %0d drops %0d hdrs %0d expected 0 1 0",
        q_data.size(), drop_cnt, q_hdr.size());
    end
  endtask

  task automatic test_back_to_back();
    rx_hdr_t exp_a, exp_b;
    exp_a = {LOCAL, SRC1, 16'h0800};
    exp_b = {BCAST, SRC2, 16'h86DD};
    clr_mon();
    send_frame(LOCAL, SRC1, 16'h0800, 8, 8'h10, 1'b0);
    send_frame(BCAST, SRC2, 16'h86DD, 6, 8'h80, 1'b0);
    idle(3);
    checks++;
    if (q_data.size() !== 14 || drop_cnt !== 0) begin
      errors++; $display("FAIL b2b_count: got bytes %0d drops %0d expected 14 0", q_data.size(), drop_cnt);
    end
    for (int i = 0; i < q_data.size(); i++) begin
      logic [7:0] ed;
      ed = (i < 8) ? 8'h10 + 8'(i) : 8'h80 + 8'(i - 8);
      checks++;
      if ({q_data[i], q_first[i], q_last[i]} !== {ed, (i == 0 || i == 8), (i == 7 || i == 13)}) begin
        errors++; $display("FAIL b2b_byte%0d: got d=%h f=%b l=%b expected d=%h f=%b l=%b",
          i, q_data[i], q_first[i], q_last[i], ed, (i == 0 || i == 8), (i == 7 || i == 13));
      end
    end
    checks++;
    if (q_hdr.size() !== 2) begin
      errors++; $display("FAIL b2b_hdr_count: got %0d expected 2", q_hdr.size());
    end else begin
      checks++;
      if (q_hdr[0] !== exp_a || q_hdr[1] !== exp_b) begin
        errors++; $display("FAIL b2b_hdr_fields: got %h / %h expected %h / %h", q_hdr[0], q_hdr[1], exp_a, exp_b);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [95:0] exp_st;
`ifdef RX_STATS_EN
    exp_st = {32'd5, 32'd1, 32'd4};
`else
    exp_st = 96'h0;
`endif
    checks++;
    if ({stat_good, stat_bad, stat_drop} !== exp_st) begin
      errors++; $display("FAIL stats_before_rst: got %h expected %h", {stat_good, stat_bad, stat_drop}, exp_st);
    end
    send_hdr(LOCAL, SRC1, 16'h0800);
    for (int i = 0; i < 10; i++) drive(1'b1, 8'h60 + 8'(i), F_PL, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.rx_data_valid_i = 1'b0;
    bus.is_payload_or_crc_i = 1'b0;
    #2;
    checks++;
    if ({bus.pl_valid_o, bus.pl_first_o, bus.pl_last_o, bus.pl_err_o, bus.hdr_valid_o, bus.frame_drop_o,
         bus.pl_data_o, bus.dst_mac_o, bus.src_mac_o, bus.ether_type_o} !== 126'h0) begin
      errors++; $display("FAIL mid_reset_outputs: got valid=%b data=%h dst=%h expected all zero",
        bus.pl_valid_o, bus.pl_data_o, bus.dst_mac_o);
    end
    idle(2);
    rst = 1'b0;
    clr_mon();
    idle(2);
    send_frame(LOCAL, SRC2, 16'h88B5, 5, 8'hC0, 1'b0);
    idle(3);
    checks++;
    if (q_data.size() !== 5 || drop_cnt !== 0) begin
      errors++; $display("FAIL post_rst_count: got bytes %0d drops %0d expected 5 0", q_data.size(), drop_cnt);
    end
    for (int i = 0; i < q_data.size(); i++) begin
      checks++;
      if ({q_data[i], q_first[i], q_last[i]} !== {8'hC0 + 8'(i), (i == 0), (i == 4)}) begin
        errors++; $display("FAIL post_rst_byte%0d: got d=%h f=%b l=%b expected d=%h f=%b l=%b",
          i, q_data[i], q_first[i], q_last[i], 8'hC0 + 8'(i), (i == 0), (i == 4));
      end
    end
    checks++;
    if ({bus.dst_mac_o, bus.src_mac_o, bus.ether_type_o} !== {LOCAL, SRC2, 16'h88B5}) begin
      errors++; $display("FAIL post_rst_hdr: got %h expected %h",
        {bus.dst_mac_o, bus.src_mac_o, bus.ether_type_o}, {LOCAL, SRC2, 16'h88B5});
    end
`ifdef RX_STATS_EN
    exp_st = {32'd1, 32'd0, 32'd0};
`else
    exp_st = 96'h0;
`endif
    checks++;
    if ({stat_good, stat_bad, stat_drop} !== exp_st) begin
      errors++; $display("FAIL stats_after_rst: got %h expected %h", {stat_good, stat_bad, stat_drop}, exp_st);
    end
  endtask

  initial begin
    test_reset();
    test_unicast(1'b0);
    test_unicast(1'b1);
    test_filter();
    test_truncated();
    test_single_and_runt();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
